// File: rtl/abuf2ddr_pkg.sv
// Shared definitions for the accumulation-buffer write-back path: bus widths,
// transfer types and the tail/data beat ratio used by both loader and write-back.
package abuf2ddr_pkg;

    localparam int BATCH   = 2;
    localparam int DATA_W  = 8;
    localparam int TAIL_W  = 16;
    localparam int DDR_W   = 16;
    localparam int TD_RATE = TAIL_W / DATA_W;

    typedef enum logic {
        ABUF_DATA = 1'b0,
        ABUF_TAIL = 1'b1
    } abuf_trans_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } abuf_state_e;

    // Bits needed to index n distinct values (at least 1).
    function automatic int bw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/abuf2ddr_fifo.sv
// Synchronous show-ahead FIFO; the head entry is visible on dout_o whenever
// the FIFO is non-empty. Push when full and pop when empty are ignored.
module sync_fifo
    import abuf2ddr_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = bw(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = bw(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push_s, do_pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = cnt_q;

    // Pointer and occupancy next-state.
    always_comb begin
        do_push_s = push_i && !full_o;
        do_pop_s  = pop_i && !empty_o;
        wr_ptr_d  = do_push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d  = do_pop_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        if (do_push_s && !do_pop_s) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!do_push_s && do_pop_s) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/abuf2ddr.sv
// Accumulation-buffer write-back: reads one PE's data or tail words and
// serialises them onto a DDR_W valid/ready stream under FIFO credit control.
module abuf2ddr
    import abuf2ddr_pkg::*;
#(
    parameter int BUF_DEPTH  = 256,
    parameter int PE_NUM     = 32,
    parameter int ADDR_W     = bw(BUF_DEPTH),
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             conf_valid,
    output logic                             conf_ready,
    input  logic                             conf_trans_type,
    input  logic [15:0]                      conf_trans_num,
    input  logic [bw(PE_NUM)-1:0]            conf_pe,
    output logic [ADDR_W-1:0]                abuf_rd_addr,
    output logic                             abuf_rd_en,
    input  logic [PE_NUM*BATCH*DATA_W-1:0]   abuf_rd_data,
    input  logic [PE_NUM*BATCH*TAIL_W-1:0]   abuf_rd_tail,
    output logic [DDR_W-1:0]                 ddr_data,
    output logic                             ddr_valid,
    input  logic                             ddr_ready,
    output logic                             ddr_last
);

    localparam int PE_W   = bw(PE_NUM);
    localparam int DENT_W = BATCH * DATA_W;
    localparam int ENT_W  = BATCH * TAIL_W;
    localparam int CNT_W  = bw(FIFO_DEPTH + 1);
    localparam int IF_W   = bw(RD_LAT + 1);
    localparam int SUB_W  = bw(TD_RATE);

    if (DDR_W != BATCH * DATA_W) begin : g_bad_ddr_w
        $error("abuf2ddr: DDR_W must equal BATCH*DATA_W");
    end
    if (TAIL_W != TD_RATE * DATA_W) begin : g_bad_tail_w
        $error("abuf2ddr: TAIL_W must be a multiple of DATA_W");
    end
    if (RD_LAT < 1 || RD_LAT > 2 || FIFO_DEPTH < RD_LAT + 2) begin : g_bad_depth
        $error("abuf2ddr: RD_LAT must be 1..2 and FIFO_DEPTH >= RD_LAT+2");
    end

    abuf_state_e      state_q, state_d;
    abuf_trans_e      type_q, type_d;
    logic [15:0]      num_q, num_d, issued_q, issued_d;
    logic [PE_W-1:0]  pe_q, pe_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [RD_LAT-1:0] pipe_q, pipe_d;
    logic [SUB_W-1:0] sub_q, sub_d;
    logic [31:0]      beat_q, beat_d, total_q, total_d;
    logic             zero_q, zero_d;

    logic [IF_W-1:0]  inflight_s;
    logic [CNT_W-1:0] fifo_count_s;
    logic             fifo_full_s, fifo_empty_s;
    logic [ENT_W-1:0] fifo_head_s, push_din_s;
    logic [DENT_W-1:0] data_slice_s;
    logic [ENT_W-1:0] tail_slice_s;
    logic             accept_s, issue_s, push_s, hs_s, pop_s;

    // Reads still travelling through the fixed-latency buffer pipeline.
    always_comb begin
        inflight_s = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight_s = inflight_s + IF_W'(pipe_q[i]);
        end
    end

    assign accept_s     = conf_valid && conf_ready;
    assign issue_s      = (state_q == ST_ISSUE) &&
                          ((int'(inflight_s) + int'(fifo_count_s)) < FIFO_DEPTH);
    assign data_slice_s = abuf_rd_data[int'(pe_q)*DENT_W +: DENT_W];
    assign tail_slice_s = abuf_rd_tail[int'(pe_q)*ENT_W +: ENT_W];
    assign push_din_s   = (type_q == ABUF_TAIL) ? tail_slice_s : ENT_W'(data_slice_s);
    assign push_s       = pipe_q[RD_LAT-1] && !fifo_full_s;
    assign hs_s         = ddr_valid && ddr_ready;
    assign pop_s        = hs_s && ((type_q == ABUF_DATA) || (sub_q == SUB_W'(TD_RATE - 1)));

    assign conf_ready   = (state_q == ST_IDLE) && !zero_q;
    assign abuf_rd_en   = issue_s;
    assign abuf_rd_addr = addr_q;
    assign ddr_valid    = !fifo_empty_s;
    assign ddr_data     = fifo_head_s[int'(sub_q)*DDR_W +: DDR_W];
    assign ddr_last     = ddr_valid && (beat_q == total_q - 32'd1);

    sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_s),
        .din_i   (push_din_s),
        .pop_i   (pop_s),
        .dout_o  (fifo_head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

    // FSM, read issue and serialiser next-state.
    always_comb begin
        state_d  = state_q;
        type_d   = type_q;
        num_d    = num_q;
        pe_d     = pe_q;
        total_d  = total_q;
        zero_d   = 1'b0;
        issued_d = issued_q;
        addr_d   = addr_q;
        beat_d   = beat_q;
        sub_d    = sub_q;
        pipe_d   = RD_LAT'({pipe_q, issue_s});

        if (issue_s) begin
            issued_d = issued_q + 16'd1;
            addr_d   = (addr_q == ADDR_W'(BUF_DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);
        end else begin
            issued_d = issued_q;
        end

        if (hs_s) begin
            beat_d = beat_q + 32'd1;
            sub_d  = pop_s ? '0 : sub_q + SUB_W'(1);
        end else begin
            beat_d = beat_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    type_d   = abuf_trans_e'(conf_trans_type);
                    num_d    = conf_trans_num;
                    pe_d     = conf_pe;
                    total_d  = conf_trans_type ? 32'(conf_trans_num) * 32'(TD_RATE)
                                               : 32'(conf_trans_num);
                    issued_d = '0;
                    addr_d   = '0;
                    beat_d   = '0;
                    sub_d    = '0;
                    if (conf_trans_num == 16'd0) begin
                        zero_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (issue_s && (issued_q == num_q - 16'd1)) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (hs_s && ddr_last) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset also discards reads still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            type_q   <= ABUF_DATA;
            num_q    <= '0;
            pe_q     <= '0;
            total_q  <= '0;
            zero_q   <= 1'b0;
            issued_q <= '0;
            addr_q   <= '0;
            beat_q   <= '0;
            sub_q    <= '0;
            pipe_q   <= '0;
        end else begin
            state_q  <= state_d;
            type_q   <= type_d;
            num_q    <= num_d;
            pe_q     <= pe_d;
            total_q  <= total_d;
            zero_q   <= zero_d;
            issued_q <= issued_d;
            addr_q   <= addr_d;
            beat_q   <= beat_d;
            sub_q    <= sub_d;
            pipe_q   <= pipe_d;
        end
    end

endmodule

// File: doc/abuf2ddr.md
Name: abuf2ddr

Overview:
Write-back stage of the accumulation buffer, running in the opposite direction to the DDR-to-accum/bias loader. On one configured transfer it reads conf_trans_num consecutive entries of one PE's accumulation buffer, either the data words or the tail words. It serialises them into a DDR_W-wide valid/ready stream for the DDR write engine. Backpressure is absorbed by a credit-controlled return FIFO, so no buffer read is ever lost.

Parameters:
BUF_DEPTH, 256, entries per PE accumulation buffer
PE_NUM, 32, number of PEs / buffers
ADDR_W, bw(BUF_DEPTH), buffer address width
RD_LAT, 1, fixed buffer read latency in cycles (1..2)
FIFO_DEPTH, 4, return FIFO entries; must be >= RD_LAT+2

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
conf_valid  in  1  transfer request
conf_ready  out  1  high only in IDLE
conf_trans_type  in  1  0 = data words, 1 = tail words
conf_trans_num  in  16  entries to read, starting at address 0
conf_pe  in  bw(PE_NUM)  PE buffer to read
abuf_rd_addr  out  ADDR_W  read address, common to all PEs
abuf_rd_en  out  1  read strobe
abuf_rd_data  in  PE_NUM*BATCH*DATA_W  per-PE data read ports, PE p at slice p
abuf_rd_tail  in  PE_NUM*BATCH*TAIL_W  per-PE tail read ports
ddr_data  out  DDR_W  output beat
ddr_valid  out  1  beat valid
ddr_ready  in  1  sink accepts
ddr_last  out  1  final beat of transfer

Behaviour:
- Width rules: DDR_W == BATCH*DATA_W; TD_RATE = TAIL_W/DATA_W. Elaboration error if either rule fails.
- Reset values: conf_ready=1, abuf_rd_en=0, abuf_rd_addr=0, ddr_valid=0, ddr_last=0. FIFO, counters and FSM all cleared.
- Reset mid-transfer aborts it. Nothing more is emitted and already-issued reads are discarded.
- Config handshake: config accepted when conf_valid && conf_ready, in cycle T. type, num and pe are latched; the block ignores config inputs until it returns to IDLE.
- FSM states IDLE, ISSUE, DRAIN:
  - IDLE -> ISSUE on accept.
  - IDLE -> IDLE if num==0: conf_ready drops for exactly one cycle, no reads, no beats.
  - ISSUE -> DRAIN after read num-1 is issued.
  - DRAIN -> IDLE in the cycle after the last beat handshakes; conf_ready=1 in that next cycle.
- Read issue: in ISSUE, abuf_rd_en=1 when inflight + fifo_count < FIFO_DEPTH.
  - Addresses run 0,1,...,num-1 and increment only on issue.
  - Any num above BUF_DEPTH is a config error; the address wraps modulo BUF_DEPTH.
- Return path: inflight tracks the rd_en shift-line of RD_LAT stages. On return, the conf_pe slice is pushed into the FIFO: data (BATCH*DATA_W) or tail (BATCH*TAIL_W), per the latched type. A push never occurs when full; credit control guarantees this.
- Serialiser:
  - Data mode: one beat per FIFO entry.
  - Tail mode: TD_RATE beats per entry, beat k = entry[k*DDR_W +: DDR_W], low slice first. This matches the loader's packing order.
  - Pop on the handshake of the entry's final beat.
- Output stream: ddr_valid = FIFO non-empty, with ddr_data and ddr_valid held stable while stalled.
  - ddr_last=1 on beat num-1 (data) or num*TD_RATE-1 (tail).
  - Total beats = num or num*TD_RATE.
- Latency: first rd_en at T+1; first ddr_valid at T+2+RD_LAT. With ddr_ready held high, throughput is 1 beat/cycle sustained.
- Simultaneous FIFO push and pop in one cycle: count is unchanged.
- ddr_ready low indefinitely: issue stops at the credit limit and resumes on drain. No data is lost or duplicated.

Decomposition:
- GLOBAL_PARAM already provides DDR_W, BATCH, DATA_W, TAIL_W and bw().
- Add to GLOBAL_PARAM: typedef enum for transfer type (ABUF_DATA=0, ABUF_TAIL=1) and localparam TD_RATE, shared with the loader.
- Sub-module: sync_fifo (WIDTH, DEPTH; push/pop/full/empty/count, show-ahead head). Instantiate it with WIDTH = BATCH*TAIL_W; data mode uses the low BATCH*DATA_W bits.
- FSM, credit counter and serialiser live in abuf2ddr.

Test Plan:
- Data, pe=5, num=8, ddr_ready=1, buffer word=(pe<<8)|addr -> 8 beats at 1/cycle, addrs 0..7 in order, ddr_last on beat 7, first ddr_valid at T+3, conf_ready back one cycle after the last handshake.
- Tail, pe=31, num=3 -> 3*TD_RATE beats, low slice first per entry, ddr_last only on the final beat.
- Data, num=20, ddr_ready toggling 1-of-3 cycles -> all 20 words exactly once, in order. FIFO never overflows (assertion) and inflight+count never exceeds 4.
- num=0 -> no rd_en, no ddr_valid; conf_ready low for exactly 1 cycle.
- rst asserted during beat 4 of num=10, then a new data transfer num=2 on pe=0 -> no beats between reset and the new accept; exactly 2 correct beats afterwards.
- conf_valid held high continuously for back-to-back transfers (num=4 on pe=1 then pe=2) -> second accepted only in IDLE; 8 beats with no gap beyond the restart latency.
